// File: rtl/alu_sweep_controller.sv
// alu_sweep_controller
// Exhaustive self-test sequencer for a pair of combinational ALUs. On start it
// walks every {op, A, B} vector (op outermost, B innermost), one per clock,
// compares the golden and suspect ALU results, counts mismatches and captures
// the first failing vector. Reports pass/fail with a one-cycle done pulse.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               begin a sweep (honoured only in IDLE)
//   abort               stop the sweep early (honoured only in RUN)
//   op_o, a_o, b_o      registered vector driven to both ALUs
//   golden_result       result of the reference ALU
//   dut_result          result of the ALU under test
//   busy                high while sweeping
//   done                one-cycle pulse at sweep completion
//   pass                set at completion when no mismatch was seen
//   mismatch_count      mismatching vectors in the current/last sweep
//   first_fail_valid    first-failure capture registers hold data
//   first_fail_vec      {op, A, B} of the first mismatch
//   first_fail_golden   golden result at the first mismatch
//   first_fail_dut      DUT result at the first mismatch
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; results of the last sweep held
// RUN   | one vector per cycle on op_o/a_o/b_o, compare and count
// DONE  | single cycle: done pulse, pass already valid

module alu_sweep_controller #(
    parameter  int WIDTH = 4,
    parameter  int OPW   = 2,
    localparam int VW    = OPW + 2 * WIDTH,
    localparam int CW    = VW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [OPW-1:0]   op_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    input  logic [WIDTH-1:0] golden_result,
    input  logic [WIDTH-1:0] dut_result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CW-1:0]    mismatch_count,
    output logic             first_fail_valid,
    output logic [VW-1:0]    first_fail_vec,
    output logic [WIDTH-1:0] first_fail_golden,
    output logic [WIDTH-1:0] first_fail_dut
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [VW-1:0] idx;
    logic          mismatch;
    logic          last_vec;

    assign mismatch = (dut_result != golden_result);
    assign last_vec = (idx == {VW{1'b1}});

    // The vector registers are the idx register itself, split into fields.
    assign op_o = idx[VW-1 -: OPW];
    assign a_o  = idx[2*WIDTH-1 -: WIDTH];
    assign b_o  = idx[WIDTH-1:0];

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                // abort wins over the last-vector transition
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (last_vec) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx               <= '0;
            mismatch_count    <= '0;
            pass              <= 1'b0;
            first_fail_valid  <= 1'b0;
            first_fail_vec    <= '0;
            first_fail_golden <= '0;
            first_fail_dut    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx               <= '0;
                        mismatch_count    <= '0;
                        pass              <= 1'b0;
                        first_fail_valid  <= 1'b0;
                        first_fail_vec    <= '0;
                        first_fail_golden <= '0;
                        first_fail_dut    <= '0;
                    end
                end
                S_RUN: begin
                    // An aborted cycle's compare is dropped; partial results hold.
                    if (!abort) begin
                        if (mismatch) begin
                            mismatch_count <= mismatch_count + CW'(1);
                            if (!first_fail_valid) begin
                                first_fail_valid  <= 1'b1;
                                first_fail_vec    <= idx;
                                first_fail_golden <= golden_result;
                                first_fail_dut    <= dut_result;
                            end
                        end
                        // pass is resolved on entry to DONE (including the last
                        // compare) so it is already valid during the done pulse.
                        if (last_vec) begin
                            pass <= (mismatch_count == '0) && !mismatch;
                        end else begin
                            idx <= idx + VW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
